alu_serial_driver: RTL
======================

Name: alu_serial_driver

Overview:
- Bit-serial ALU controller: the initiator side of the 1-bit ALU slice interface (slice inputs a, b, carryIn, ALUOp[3:0]; outputs result, carryOut).
- Accepts a WIDTH-bit operation via valid/ready and decodes the opcode to the slice ALUOp encoding.
- Drives one external 1-bit slice LSB-first for WIDTH cycles, chaining the carry through an internal register, and returns result plus flags via valid/ready.
- Sits between the datapath issue logic and a single shared 1-bit ALU slice.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 SLT, 110/111 illegal
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- start_valid  input  1  request valid
- start_ready  output  1  request accepted when start_valid & start_ready at a clk edge
- slice_a  output  1  bit i of A to slice
- slice_b  output  1  bit i of B to slice
- slice_cin  output  1  carry into slice
- slice_op  output  4  ALUOp to slice: [3] invert A, [2] invert B, [1:0] 00 AND / 01 OR / 10 ADD / 11 yields 0
- slice_result  input  1  slice result bit (combinational from slice_* outputs)
- slice_cout  input  1  slice carry out
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- carry_out  output  1  carry out of MSB (ADD/SUB only, else 0)
- overflow  output  1  signed overflow (ADD/SUB only, else 0)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: state IDLE; start_ready=1; result_valid=0; result=0; zero=0; carry_out=0; overflow=0; busy=0; slice_* outputs 0; bit counter 0; carry register 0. Reset asserted mid-RUN or mid-DONE aborts the operation with no result delivered.
- Opcode-to-slice_op decode: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0110, illegal 0011.
- Initial carry: 1 for SUB/SLT, 0 otherwise.
- FSM IDLE: start_ready=1. On handshake, latch op/a_in/b_in, load carry register with the initial carry, clear counter and result shift register, go to RUN.
- FSM RUN (exactly WIDTH cycles, counter i = 0..WIDTH-1):
  - slice_a=A[i], slice_b=B[i], slice_op=decoded, slice_cin=carry register.
  - At each edge, capture slice_result into result bit i and slice_cout into the carry register.
  - At i=WIDTH-2, also capture slice_cout as the carry into the MSB (c_msb_in).
  - After the i=WIDTH-1 edge, go to DONE.
  - start_ready=0; slice_* outputs are 0 outside RUN.
- DONE:
  - result_valid=1. Outputs are stable until result_valid & result_ready at an edge, then go to IDLE.
  - start_ready stays 0 in DONE. No request/result overlap.
- Latency: handshake at edge E gives result_valid high after edge E+WIDTH. With result_ready held high, the next request can be accepted at edge E+WIDTH+2.
- Flags:
  - ADD/SUB: overflow = c_msb_in ^ final carry; carry_out = final carry (SUB carry=1 means no borrow).
  - SLT: result = {WIDTH-1 zeros, MSB of difference ^ signed overflow}; carry_out=0; overflow=0.
  - AND/OR/NOR: carry_out=0; overflow=0.
  - Illegal op: full WIDTH-cycle RUN with slice_op 0011, so result=0 and zero=1; no error signalled.
  - zero is computed on the final result value, including SLT.
- Inputs a_in/b_in/op changing after the handshake have no effect on the operation in flight.
- start_valid in RUN/DONE is ignored. The requester holds the request until start_ready.

Test Plan:
- WIDTH=8, ADD 0x05+0x03, result_ready=1 -> result_valid exactly 8 cycles after accept; result=0x08, zero=0, carry_out=0, overflow=0; slice_op=0010 throughout RUN.
- WIDTH=8, SUB 0x10-0x10 -> result=0x00, zero=1, carry_out=1, overflow=0; slice_cin=1 in cycle 0; slice_op=0110.
- WIDTH=8, ADD 0x7F+0x01 -> result=0x80, overflow=1, carry_out=0. Then SLT a=0xFF, b=0x01 -> result=0x01. Then SLT a=0x80, b=0x7F (MSB of difference 0, overflow set) -> result=0x01.
- WIDTH=8, NOR 0xF0,0x0C -> result=0x03, slice_op=1100. Illegal op 111 -> result=0x00, zero=1, same latency.
- Backpressure: result_ready=0 for 5 cycles after result_valid -> result, flags, and result_valid stable; start_ready=0; a new start_valid is not accepted until one cycle after the result handshake.
- Reset asserted asynchronously at RUN cycle 3 -> all outputs at reset values immediately (not at the next edge). After release, a fresh ADD 0x01+0x01 -> result=0x02.

Source files
------------

// File: rtl/alu_serial_driver_if.sv
// rtl/alu_serial_driver_if.sv - request, result and slice signals of the serial ALU driver
interface alu_serial_driver_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             start_valid;
  logic             start_ready;

  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [3:0]       slice_op;
  logic             slice_result;
  logic             slice_cout;

  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    input  op, a_in, b_in, start_valid,
    input  slice_result, slice_cout,
    input  result_ready,
    output start_ready,
    output slice_a, slice_b, slice_cin, slice_op,
    output result_valid, result, zero, carry_out, overflow, busy
  );

  modport slave (
    output op, a_in, b_in, start_valid,
    output slice_result, slice_cout,
    output result_ready,
    input  start_ready,
    input  slice_a, slice_b, slice_cin, slice_op,
    input  result_valid, result, zero, carry_out, overflow, busy
  );
endinterface

// File: rtl/alu_serial_driver.sv
// rtl/alu_serial_driver.sv - bit-serial ALU controller driving a shared 1-bit slice
// LSB-first, one bit per cycle, carry chained through r_carry.
module alu_serial_driver #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_serial_driver_if.master  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cmsb;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_init_carry;
  logic             w_last;
  logic [3:0]       w_dec_op;
  logic             w_start_ready;
  logic             w_result_valid;
  logic             w_busy;
  logic             w_slice_a;
  logic             w_slice_b;
  logic             w_slice_cin;
  logic [3:0]       w_slice_op;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf_raw;
  logic             w_final_cout;
  logic             w_final_ovf;

  function automatic logic [3:0] decode_op(input logic [2:0] op);
    case (op)
      OP_AND:  decode_op = 4'b0000;
      OP_OR:   decode_op = 4'b0001;
      OP_ADD:  decode_op = 4'b0010;
      OP_SUB:  decode_op = 4'b0110;
      OP_NOR:  decode_op = 4'b1100;
      OP_SLT:  decode_op = 4'b0110;
      default: decode_op = 4'b0011;
    endcase
  endfunction

  assign w_dec_op     = decode_op(r_op);
  assign w_accept     = (r_state == ST_IDLE) && bus.start_valid;
  assign w_init_carry = (bus.op == OP_SUB) || (bus.op == OP_SLT);
  assign w_last       = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_start_ready  = 1'b0;
    w_result_valid = 1'b0;
    w_busy         = 1'b0;
    w_slice_a      = 1'b0;
    w_slice_b      = 1'b0;
    w_slice_cin    = 1'b0;
    w_slice_op     = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        w_start_ready = 1'b1;
        if (bus.start_valid) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy      = 1'b1;
        w_slice_a   = r_a[0];
        w_slice_b   = r_b[0];
        w_slice_cin = r_carry;
        w_slice_op  = w_dec_op;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_busy         = 1'b1;
        w_result_valid = 1'b1;
        if (bus.result_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Final word assembled from the MSB bit arriving on the last RUN edge.
  always_comb begin
    w_shifted    = {bus.slice_result, r_shift[WIDTH-1:1]};
    w_ovf_raw    = r_cmsb ^ bus.slice_cout;
    w_final      = w_shifted;
    w_final_cout = 1'b0;
    w_final_ovf  = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_final_cout = bus.slice_cout;
        w_final_ovf  = w_ovf_raw;
      end
      OP_SLT: begin
        w_final = {{(WIDTH-1){1'b0}}, bus.slice_result ^ w_ovf_raw};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= 3'b000;
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_zero  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_shift <= '0;
            r_cnt   <= '0;
            r_carry <= w_init_carry;
            r_cmsb  <= 1'b0;
            r_zero  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= bus.slice_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == PENULT) begin
            r_cmsb <= bus.slice_cout;
          end
          if (w_last) begin
            r_shift <= w_final;
            r_zero  <= (w_final == '0);
            r_cout  <= w_final_cout;
            r_ovf   <= w_final_ovf;
          end else begin
            r_shift <= w_shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready  = w_start_ready;
  assign bus.result_valid = w_result_valid;
  assign bus.busy         = w_busy;
  assign bus.slice_a      = w_slice_a;
  assign bus.slice_b      = w_slice_b;
  assign bus.slice_cin    = w_slice_cin;
  assign bus.slice_op     = w_slice_op;
  assign bus.result       = r_shift;
  assign bus.zero         = r_zero;
  assign bus.carry_out    = r_cout;
  assign bus.overflow     = r_ovf;
endmodule
